// File: rtl/rtc_bus_cycle_gen.sv
// rtl/rtc_bus_cycle_gen.sv - bus cycle generator for the multiplexed address/data RTC (optional: RTC_BUS_ABORT_EN)
module rtc_bus_cycle_gen #(
  parameter int T_PH  = 4,
  parameter int T_REC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       En,
  input  logic       wr_rd,
  input  logic [7:0] Dir_in,
  output logic       DIR,
  output logic       DAT,
  output logic       DAT2,
  output logic       cambio_estado,
  output logic       cambio_estado2,
  output logic [7:0] Dato_L,
  output logic       busy,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD,
  output logic [7:0] ad_out,
  output logic       ad_oe,
`ifdef RTC_BUS_ABORT_EN
  output logic       aborted,
`endif
  input  logic [7:0] ad_in
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    A_REQ  = 4'd1,
    A_LOAD = 4'd2,
    A_LOW  = 4'd3,
    A_HIGH = 4'd4,
    D_REQ  = 4'd5,
    D_LOAD = 4'd6,
    W_LOW  = 4'd7,
    W_HIGH = 4'd8,
    R_LOW  = 4'd9,
    R_HIGH = 4'd10,
    DONE   = 4'd11,
    REC    = 4'd12
  } state_t;

  localparam logic [7:0] PH_LOAD  = 8'(T_PH - 1);
  localparam logic [7:0] REC_LOAD = 8'(T_REC - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_load;
  logic       type_reg;
  logic       phase_end;

  assign phase_end = (cnt == 8'd0);

`ifdef RTC_BUS_ABORT_EN
  logic abort_take;

  // A request withdrawn while the bus is owned cuts the transaction short
  always_comb begin
    abort_take = 1'b0;
    case (state)
      A_LOW, A_HIGH, D_REQ, D_LOAD, W_LOW, W_HIGH, R_LOW, R_HIGH: abort_take = ~En;
      default: abort_take = 1'b0;
    endcase
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing through address phase, then write or read data phase
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (En) state_nxt = A_REQ;
      A_REQ:   state_nxt = A_LOAD;
      A_LOAD:  state_nxt = A_LOW;
      A_LOW:   if (phase_end) state_nxt = A_HIGH;
      A_HIGH:  if (phase_end) state_nxt = type_reg ? D_REQ : R_LOW;
      D_REQ:   state_nxt = D_LOAD;
      D_LOAD:  state_nxt = W_LOW;
      W_LOW:   if (phase_end) state_nxt = W_HIGH;
      W_HIGH:  if (phase_end) state_nxt = DONE;
      R_LOW:   if (phase_end) state_nxt = R_HIGH;
      R_HIGH:  if (phase_end) state_nxt = DONE;
      DONE:    state_nxt = REC;
      REC:     if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef RTC_BUS_ABORT_EN
    if (abort_take) state_nxt = REC;
`endif
  end

  // Pin levels and strobes decoded from the current state only
  always_comb begin
    CS_n           = 1'b1;
    RD_n           = 1'b1;
    WR_n           = 1'b1;
    AD             = 1'b1;
    ad_oe          = 1'b0;
    DIR            = 1'b0;
    DAT            = 1'b0;
    DAT2           = 1'b0;
    cambio_estado  = 1'b0;
    cambio_estado2 = 1'b0;
    busy           = (state != IDLE);
    unique case (state)
      IDLE:   ;
      A_REQ:  DIR = 1'b1;
      A_LOAD: ;
      A_LOW: begin
        CS_n  = 1'b0;
        WR_n  = 1'b0;
        AD    = 1'b0;
        ad_oe = 1'b1;
      end
      A_HIGH: begin
        CS_n  = 1'b0;
        AD    = 1'b0;
        ad_oe = 1'b1;
      end
      D_REQ: begin
        DAT   = 1'b1;
        CS_n  = 1'b0;
        AD    = 1'b0;
        ad_oe = 1'b1;
      end
      D_LOAD: begin
        CS_n  = 1'b0;
        AD    = 1'b0;
        ad_oe = 1'b1;
      end
      W_LOW: begin
        CS_n  = 1'b0;
        WR_n  = 1'b0;
        ad_oe = 1'b1;
      end
      W_HIGH: begin
        CS_n  = 1'b0;
        ad_oe = 1'b1;
      end
      R_LOW: begin
        CS_n = 1'b0;
        RD_n = 1'b0;
      end
      R_HIGH: begin
        CS_n = 1'b0;
        DAT2 = (cnt == PH_LOAD);
      end
      DONE: begin
        cambio_estado  = type_reg;
        cambio_estado2 = ~type_reg;
      end
      REC:     ;
      default: ;
    endcase
  end

  // Reload value for the phase counter on entry to a timed state
  always_comb begin
    cnt_load = 8'd0;
    case (state_nxt)
      A_LOW, A_HIGH, W_LOW, W_HIGH, R_LOW, R_HIGH: cnt_load = PH_LOAD;
      REC:     cnt_load = REC_LOAD;
      default: cnt_load = 8'd0;
    endcase
  end

  // Phase counter: reload on every state change, count down to zero inside a state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt <= 8'd0;
    else if (state_nxt != state) cnt <= cnt_load;
    else if (cnt != 8'd0)        cnt <= cnt - 8'd1;
  end

  // Datapath: cycle type, bus drive byte and read-back byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      type_reg <= 1'b0;
      ad_out   <= 8'd0;
      Dato_L   <= 8'd0;
    end else begin
      if (state == IDLE && En)                     type_reg <= wr_rd;
      if (state == A_LOAD || state == D_LOAD)      ad_out   <= Dir_in;
      if (state == R_LOW && state_nxt == R_HIGH)   Dato_L   <= ad_in;
    end
  end

`ifdef RTC_BUS_ABORT_EN
  // One-cycle flag coinciding with the first recovery cycle after an abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) aborted <= 1'b0;
    else        aborted <= abort_take;
  end
`endif

endmodule

// File: tb/tb_rtc_bus_cycle_gen.sv
// tb/tb_rtc_bus_cycle_gen.sv - scoreboard bench for rtc_bus_cycle_gen
module tb_rtc_bus_cycle_gen;

  localparam int EV_WRLO = 0, EV_WRHI = 1, EV_RDLO = 2, EV_RDHI = 3, EV_DIR = 4;
  localparam int EV_DAT = 5, EV_DAT2 = 6, EV_CE = 7, EV_CE2 = 8, EV_ABT = 9;

  typedef struct {
    int         kind;
    int         cyc;
    logic [8:0] data;
  } ev_t;

  typedef struct packed {
    logic       dir, dat, dat2, ce, ce2, wr_n, rd_n, ad, ad_oe, cs_n, busy, abt;
    logic [7:0] ad_out, dato;
  } obs_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  q0[$];
  ev_t  q1[$];
  obs_t o0, o1;
  obs_t p0 = '1;
  obs_t p1 = '1;

  logic       rst0 = 1'b0, rst1 = 1'b0;
  logic       En0 = 1'b0, En1 = 1'b0, wr_rd0 = 1'b0, wr_rd1 = 1'b0;
  logic [7:0] Dir_in0 = 8'd0, Dir_in1 = 8'd0, ad_in0 = 8'd0, ad_in1 = 8'd0;
  logic [7:0] addr0 = 8'd0, data0 = 8'd0, addr1 = 8'd0, data1 = 8'd0;

  logic       DIR0, DAT0, DAT20, CE0, CE20, busy0, CS_n0, RD_n0, WR_n0, AD0, ad_oe0;
  logic       DIR1, DAT1, DAT21, CE1, CE21, busy1, CS_n1, RD_n1, WR_n1, AD1, ad_oe1;
  logic [7:0] Dato_L0, ad_out0, Dato_L1, ad_out1;
  logic       abt0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtc_bus_cycle_gen #(.T_PH(4), .T_REC(4)) u_dut0 (
    .clk(clk), .reset(rst0), .En(En0), .wr_rd(wr_rd0), .Dir_in(Dir_in0),
    .DIR(DIR0), .DAT(DAT0), .DAT2(DAT20), .cambio_estado(CE0), .cambio_estado2(CE20),
    .Dato_L(Dato_L0), .busy(busy0), .CS_n(CS_n0), .RD_n(RD_n0), .WR_n(WR_n0),
    .AD(AD0), .ad_out(ad_out0), .ad_oe(ad_oe0),
`ifdef RTC_BUS_ABORT_EN
    .aborted(abt0),
`endif
    .ad_in(ad_in0)
  );

`ifdef RTC_BUS_ABORT_EN
  logic abt1;
`else
  assign abt0 = 1'b0;
`endif

  rtc_bus_cycle_gen #(.T_PH(1), .T_REC(2)) u_dut1 (
    .clk(clk), .reset(rst1), .En(En1), .wr_rd(wr_rd1), .Dir_in(Dir_in1),
    .DIR(DIR1), .DAT(DAT1), .DAT2(DAT21), .cambio_estado(CE1), .cambio_estado2(CE21),
    .Dato_L(Dato_L1), .busy(busy1), .CS_n(CS_n1), .RD_n(RD_n1), .WR_n(WR_n1),
    .AD(AD1), .ad_out(ad_out1), .ad_oe(ad_oe1),
`ifdef RTC_BUS_ABORT_EN
    .aborted(abt1),
`endif
    .ad_in(ad_in1)
  );

  assign o0 = {DIR0, DAT0, DAT20, CE0, CE20, WR_n0, RD_n0, AD0, ad_oe0, CS_n0, busy0, abt0,
               ad_out0, Dato_L0};
`ifdef RTC_BUS_ABORT_EN
  assign o1 = {DIR1, DAT1, DAT21, CE1, CE21, WR_n1, RD_n1, AD1, ad_oe1, CS_n1, busy1, abt1,
               ad_out1, Dato_L1};
`else
  assign o1 = {DIR1, DAT1, DAT21, CE1, CE21, WR_n1, RD_n1, AD1, ad_oe1, CS_n1, busy1, 1'b0,
               ad_out1, Dato_L1};
`endif

  function automatic string kname(input int k);
    case (k)
      EV_WRLO: return "wr_fall";
      EV_WRHI: return "wr_rise";
      EV_RDLO: return "rd_fall";
      EV_RDHI: return "rd_rise";
      EV_DIR:  return "DIR";
      EV_DAT:  return "DAT";
      EV_DAT2: return "DAT2";
      EV_CE:   return "cambio_estado";
      EV_CE2:  return "cambio_estado2";
      default: return "aborted";
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input int kind, input int c, input logic [8:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic see(input int idx, input int kind, input logic [8:0] d);
    ev_t e;
    total++;
    if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
      bad++;
      $display("FAIL unexpected_%s dut%0d: got cyc=%0d data=%h required no event",
               kname(kind), idx, cyc, d);
      return;
    end
    if (idx == 0) e = q0.pop_front();
    else          e = q1.pop_front();
    if (e.kind != kind || e.cyc != cyc || e.data !== d) begin
      bad++;
      $display("FAIL event dut%0d: got %s cyc=%0d data=%h required %s cyc=%0d data=%h",
               idx, kname(kind), cyc, d, kname(e.kind), e.cyc, e.data);
    end
  endtask

  task automatic check_obs(input int idx, input obs_t c, input obs_t p);
    if (!c.wr_n && p.wr_n)  see(idx, EV_WRLO, {c.ad, c.ad_out});
    if (c.wr_n && !p.wr_n)  see(idx, EV_WRHI, 9'd0);
    if (!c.rd_n && p.rd_n)  see(idx, EV_RDLO, {c.ad, 7'd0, c.ad_oe});
    if (c.rd_n && !p.rd_n)  see(idx, EV_RDHI, 9'd0);
    if (c.dir)              see(idx, EV_DIR, 9'd0);
    if (c.dat)              see(idx, EV_DAT, 9'd0);
    if (c.dat2)             see(idx, EV_DAT2, {1'b0, c.dato});
    if (c.ce)               see(idx, EV_CE, 9'd0);
    if (c.ce2)              see(idx, EV_CE2, 9'd0);
    if (c.abt)              see(idx, EV_ABT, 9'd0);
    chk("strobe_onehot0", 32'($onehot0({c.dir, c.dat, c.dat2, c.ce, c.ce2})), 32'd1);
    chk("rd_wr_overlap", 32'(!c.rd_n && !c.wr_n), 32'd0);
    chk("oe_during_read", 32'(!c.rd_n && c.ad_oe), 32'd0);
  endtask

  // Monitor: decode bus edges and strobes, compare against scoreboard
  always @(negedge clk) begin
    check_obs(0, o0, p0);
    p0 = o0;
    check_obs(1, o1, p1);
    p1 = o1;
  end

  // Sequencer model: supply address after DIR and write data after DAT
  always @(negedge clk) begin
    if (DIR0) Dir_in0 = addr0;
    if (DAT0) Dir_in0 = data0;
    if (DIR1) Dir_in1 = addr1;
    if (DAT1) Dir_in1 = data1;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_txn(input int idx, input int base, input bit wr,
                          input logic [7:0] a, input logic [7:0] d, input logic [7:0] rd);
    int tp;
    tp = (idx == 0) ? 4 : 1;
    push(idx, EV_DIR, base, 9'd0);
    push(idx, EV_WRLO, base + 2, {1'b0, a});
    push(idx, EV_WRHI, base + tp + 2, 9'd0);
    if (wr) begin
      push(idx, EV_DAT, base + 2*tp + 2, 9'd0);
      push(idx, EV_WRLO, base + 2*tp + 4, {1'b1, d});
      push(idx, EV_WRHI, base + 3*tp + 4, 9'd0);
      push(idx, EV_CE, base + 4*tp + 4, 9'd0);
    end else begin
      push(idx, EV_RDLO, base + 2*tp + 2, 9'h100);
      push(idx, EV_RDHI, base + 3*tp + 2, 9'd0);
      push(idx, EV_DAT2, base + 3*tp + 2, {1'b0, rd});
      push(idx, EV_CE2, base + 4*tp + 2, 9'd0);
    end
  endtask

  task automatic run_txn(input int idx, input bit wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] rd);
    int tp, trec, base, done_c;
    tp   = (idx == 0) ? 4 : 1;
    trec = (idx == 0) ? 4 : 2;
    @(negedge clk);
    if (idx == 0) begin En0 = 1'b1; wr_rd0 = wr; addr0 = a; data0 = d; ad_in0 = rd; end
    else          begin En1 = 1'b1; wr_rd1 = wr; addr1 = a; data1 = d; ad_in1 = rd; end
    base   = cyc + 1;
    done_c = wr ? base + 4*tp + 4 : base + 4*tp + 2;
    push_txn(idx, base, wr, a, d, rd);
    wait_until(base);
    if (idx == 0) wr_rd0 = ~wr;
    else          wr_rd1 = ~wr;
    wait_until(done_c);
    if (idx == 0) En0 = 1'b0;
    else          En1 = 1'b0;
    wait_until(done_c + trec + 2);
    chk("queue_drained", (idx == 0) ? 32'(q0.size()) : 32'(q1.size()), 32'd0);
  endtask

  initial begin
    int base, done1, base2;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(CS_n0), 32'd1);
    chk("rst_rd_n", 32'(RD_n0), 32'd1);
    chk("rst_wr_n", 32'(WR_n0), 32'd1);
    chk("rst_ad", 32'(AD0), 32'd1);
    chk("rst_ad_oe", 32'(ad_oe0), 32'd0);
    chk("rst_ad_out", 32'(ad_out0), 32'd0);
    chk("rst_dato", 32'(Dato_L0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(0, 1'b1, 8'hF1, 8'h01, 8'h00);
    run_txn(0, 1'b0, 8'h21, 8'h00, 8'h37);
    run_txn(0, 1'b1, 8'h0A, 8'hC3, 8'hEE);
    chk("dato_hold", 32'(Dato_L0), 32'h37);

    @(negedge clk);
    En0 = 1'b1; wr_rd0 = 1'b1; addr0 = 8'h12; data0 = 8'h34;
    base  = cyc + 1;
    done1 = base + 20;
    base2 = done1 + 4 + 2;
    push_txn(0, base, 1'b1, 8'h12, 8'h34, 8'h00);
    push_txn(0, base2, 1'b1, 8'h12, 8'h34, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      wait_until(done1 + i);
      chk("rec_cs_n", 32'(CS_n0), 32'd1);
      chk("rec_busy", 32'(busy0), 32'd1);
    end
    wait_until(base2);
    En0 = 1'b0;
    wait_until(base2 + 28);
    chk("b2b_drained", 32'(q0.size()), 32'd0);

`ifdef RTC_BUS_ABORT_EN
    @(negedge clk);
    En0 = 1'b1; wr_rd0 = 1'b0; addr0 = 8'h21; ad_in0 = 8'h99;
    base = cyc + 1;
    push(0, EV_DIR, base, 9'd0);
    push(0, EV_WRLO, base + 2, 9'h021);
    push(0, EV_WRHI, base + 6, 9'd0);
    push(0, EV_RDLO, base + 10, 9'h100);
    push(0, EV_RDHI, base + 12, 9'd0);
    push(0, EV_ABT, base + 12, 9'd0);
    wait_until(base + 11);
    En0 = 1'b0;
    wait_until(base + 20);
    chk("abort_drained", 32'(q0.size()), 32'd0);
    chk("abort_dato", 32'(Dato_L0), 32'h37);
`endif

    @(negedge clk);
    En0 = 1'b1; wr_rd0 = 1'b1; addr0 = 8'h55; data0 = 8'h66;
    base = cyc + 1;
    push(0, EV_DIR, base, 9'd0);
    push(0, EV_WRLO, base + 2, 9'h055);
    push(0, EV_WRHI, base + 6, 9'd0);
    wait_until(base + 7);
    #1 rst0 = 1'b0;
    En0 = 1'b0;
    #1;
    chk("arst_cs_n", 32'(CS_n0), 32'd1);
    chk("arst_wr_n", 32'(WR_n0), 32'd1);
    chk("arst_ad_oe", 32'(ad_oe0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    wait_until(base + 10);
    rst0 = 1'b1;
    wait_until(base + 40);
    chk("arst_drained", 32'(q0.size()), 32'd0);
    run_txn(0, 1'b1, 8'hF1, 8'h01, 8'h00);

    run_txn(1, 1'b0, 8'h21, 8'h00, 8'hA5);
    chk("tph1_dato", 32'(Dato_L1), 32'hA5);
    run_txn(1, 1'b1, 8'h3C, 8'h5A, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
